// File: rtl/hja_sw_writer_pkg.sv
// Shared types and constants for the front-panel debug writer and the LED
// debug mux that decodes its exported state.
package hja_sw_writer_pkg;

  typedef logic [15:0] RegValue;
  typedef logic [15:0] RegAddr;
  typedef logic [1:0]  DbgStateBus;

  localparam DbgStateBus DBG_S_IDLE = 2'd0;
  localparam DbgStateBus DBG_S_ADDR = 2'd1;
  localparam DbgStateBus DBG_S_REQ  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = DBG_S_IDLE,
    S_ADDR = DBG_S_ADDR,
    S_REQ  = DBG_S_REQ
  } wr_state_e;

  function automatic logic is_req_state(input wr_state_e s);
    return (s == S_REQ);
  endfunction

endpackage

// File: rtl/hja_sw_writer_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, consecutive-cycle debouncer and a
// rising-edge detector that yields a single-cycle press pulse.
module hja_btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        db_q, db_d;
  logic        db_prev_q;
  logic [15:0] cnt_q, cnt_d;

  // db flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign level = db_q;
  assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/hja_sw_writer.sv
// Front-panel debug writer: address press, data press, then one held write
// request toward the debug port until done or timeout.
module hja_sw_writer
  import hja_sw_writer_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TIMEOUT_CYCLES  = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [15:0] sw,
  input  logic       btn,
  input  logic       btn_cancel,
  output logic       dbg_wr_req,
  output logic [15:0] dbg_wr_addr,
  output logic [15:0] dbg_wr_data,
  input  logic       dbg_wr_done,
  output logic       hold,
  output logic [1:0] dbg_state,
  output logic       dbg_err,
  output logic [7:0] dbg_wr_count
);

  // Handshake: dbg_wr_req is a level held for the whole of S_REQ; the target
  // answers with dbg_wr_done, sampled on each S_REQ edge, and a done seen on
  // an edge ends the request on that same edge (done beats timeout).

  logic enter_press, cancel_press;

  hja_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn),
    .level (),
    .press (enter_press)
  );

  hja_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_cancel (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_cancel),
    .level (),
    .press (cancel_press)
  );

  wr_state_e   state_q, state_d;
  RegAddr      addr_q, addr_d;
  RegValue     data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enter_press) state_d = S_ADDR;
      S_ADDR: begin
        if (cancel_press)     state_d = S_IDLE;
        else if (enter_press) state_d = S_REQ;
      end
      S_REQ:  if (dbg_wr_done || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dbg_wr_req = is_req_state(state_q);
    hold       = is_req_state(state_q);
    dbg_state  = state_q;
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (enter_press) begin
          addr_d = sw;
          err_d  = 1'b0;
        end
      end
      S_ADDR: begin
        if (!cancel_press && enter_press) begin
          data_d = sw;
          tmo_d  = '0;
        end
      end
      S_REQ: begin
        if (dbg_wr_done)  count_d = count_q + 8'd1;
        else if (tmo_hit) err_d   = 1'b1;
        else              tmo_d   = tmo_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      tmo_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dbg_wr_addr  = addr_q;
  assign dbg_wr_data  = data_q;
  assign dbg_err      = err_q;
  assign dbg_wr_count = count_q;

endmodule

// File: tb/tb_hja_sw_writer.sv
// Bench for hja_sw_writer with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=8; the
// target model raises done on a chosen S_REQ cycle.
module tb_hja_sw_writer;

  localparam int DB = 4;
  localparam int TO = 8;
  localparam int W  = 49;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        btn, btn_cancel;
  logic        dbg_wr_req, hold, dbg_err, dbg_wr_done;
  logic [15:0] dbg_wr_addr, dbg_wr_data;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_wr_count;

  always #5 clk = ~clk;

  hja_sw_writer #(.DEBOUNCE_CYCLES(16'd4), .TIMEOUT_CYCLES(8'd8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .btn_cancel   (btn_cancel),
    .dbg_wr_req   (dbg_wr_req),
    .dbg_wr_addr  (dbg_wr_addr),
    .dbg_wr_data  (dbg_wr_data),
    .dbg_wr_done  (dbg_wr_done),
    .hold         (hold),
    .dbg_state    (dbg_state),
    .dbg_err      (dbg_err),
    .dbg_wr_count (dbg_wr_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard entry: {addr, data, count, err, req_len}
  logic [W-1:0] exp_q[$];
  int           done_at   = 0;
  int           req_len   = 0;
  int           req_rises = 0;
  logic         prev_req  = 1'b0;

  logic [15:0] m_addr = '0, m_data = '0;
  logic [7:0]  m_cnt  = '0;
  logic        m_err  = 1'b0;

  // Target model and transaction monitor.
  always @(negedge clk) begin
    if (rst) begin
      req_len     = 0;
      prev_req    = 1'b0;
      dbg_wr_done = 1'b0;
    end else begin
      if (dbg_wr_req) begin
        if (!prev_req) req_rises++;
        req_len++;
        check("hold_in_req", hold, 1'b1);
        dbg_wr_done = (done_at != 0) && (req_len == done_at);
      end else begin
        dbg_wr_done = 1'b0;
        if (prev_req) begin
          check("sb_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("txn_addr",  dbg_wr_addr,  e[48:33]);
            check("txn_data",  dbg_wr_data,  e[32:17]);
            check("txn_count", dbg_wr_count, e[16:9]);
            check("txn_err",   dbg_err,      e[8]);
            check("txn_len",   req_len,      e[7:0]);
            check("txn_hold",  hold,         1'b0);
          end
        end
        req_len = 0;
      end
      prev_req = dbg_wr_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_enter(input logic [15:0] v);
    sw  = v;
    btn = 1'b1;
    tick(DB + 6);
    btn = 1'b0;
    tick(DB + 6);
  endtask

  task automatic press_cancel();
    btn_cancel = 1'b1;
    tick(DB + 6);
    btn_cancel = 1'b0;
    tick(DB + 6);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (dbg_state != 2'd0 && k < 50) begin
      tick(1);
      k++;
    end
    check(tag, dbg_state, 2'd0);
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d, input int dn);
    logic ok;
    ok      = (dn >= 1) && (dn <= TO);
    done_at = dn;
    m_addr  = a;
    m_data  = d;
    if (ok) m_cnt = m_cnt + 8'd1;
    m_err   = !ok;
    exp_q.push_back({a, d, m_cnt, m_err, 8'(ok ? dn : TO)});
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int dn);
    expect_write(a, d, dn);
    press_enter(a);
    press_enter(d);
    wait_idle("write_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int   rises0;
    int   k;

    rst = 1'b1; sw = '0; btn = 1'b0; btn_cancel = 1'b0; dbg_wr_done = 1'b0;
    tick(3);
    check("rst_state", dbg_state, 2'd0);
    check("rst_req",   dbg_wr_req, 1'b0);
    check("rst_hold",  hold, 1'b0);
    check("rst_err",   dbg_err, 1'b0);
    check("rst_count", dbg_wr_count, 8'd0);
    check("rst_addr",  dbg_wr_addr, 16'h0);
    check("rst_data",  dbg_wr_data, 16'h0);
    rst = 1'b0;
    tick(2);

    // Normal write, done on the 4th S_REQ cycle.
    expect_write(16'h1234, 16'hBEEF, 4);
    press_enter(16'h1234);
    check("norm_addr_state", dbg_state, 2'd1);
    check("norm_addr", dbg_wr_addr, 16'h1234);
    press_enter(16'hBEEF);
    wait_idle("norm_idle");
    check("norm_count", dbg_wr_count, 8'd1);
    check("norm_data", dbg_wr_data, 16'hBEEF);

    // Bounce rejection: 3 high / 2 low for 40 cycles.
    sw  = 16'h5555;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      btn = 1'b1;
      for (int j = 0; j < 3; j++) begin tick(1); if (dbg_state != 2'd0) bad = 1'b1; end
      btn = 1'b0;
      for (int j = 0; j < 2; j++) begin tick(1); if (dbg_state != 2'd0) bad = 1'b1; end
    end
    for (int j = 0; j < DB + 6; j++) begin tick(1); if (dbg_state != 2'd0) bad = 1'b1; end
    check("bounce_state", bad, 1'b0);
    check("bounce_addr", dbg_wr_addr, m_addr);

    // Timeout, then err clears on next address press, then cancel keeps latches.
    do_write(16'hA5A5, 16'h5A5A, 0);
    check("tmo_err", dbg_err, 1'b1);
    check("tmo_count", dbg_wr_count, m_cnt);
    press_enter(16'h0F0F);
    check("err_clear", dbg_err, 1'b0);
    check("err_clear_state", dbg_state, 2'd1);
    press_cancel();
    check("cancel_addr_state", dbg_state, 2'd0);
    check("cancel_keep_addr", dbg_wr_addr, 16'h0F0F);
    check("cancel_keep_data", dbg_wr_data, 16'h5A5A);

    // Press and cancel together in S_ADDR: cancel wins.
    press_enter(16'h1111);
    check("prio_addr_state", dbg_state, 2'd1);
    rises0 = req_rises;
    sw = 16'h2222; btn = 1'b1; btn_cancel = 1'b1;
    tick(DB + 6);
    btn = 1'b0; btn_cancel = 1'b0;
    tick(DB + 6);
    check("prio_state", dbg_state, 2'd0);
    check("prio_no_req", req_rises, rises0);
    check("prio_data", dbg_wr_data, 16'h5A5A);

    // Cancel in S_IDLE is ignored.
    press_cancel();
    check("idle_cancel_state", dbg_state, 2'd0);

    // Cancel during S_REQ is ignored; done on 8th cycle beats the timeout.
    expect_write(16'h3333, 16'h4444, 8);
    press_enter(16'h3333);
    sw = 16'h4444; btn = 1'b1;
    k = 0;
    while (!dbg_wr_req && k < 30) begin tick(1); k++; end
    check("coll_req_seen", dbg_wr_req, 1'b1);
    btn_cancel = 1'b1;
    tick(DB + 6);
    btn = 1'b0; btn_cancel = 1'b0;
    tick(DB + 6);
    wait_idle("coll_idle");
    check("coll_err", dbg_err, 1'b0);
    check("coll_count", dbg_wr_count, m_cnt);

    // Async reset mid-request.
    done_at = 0;
    press_enter(16'hC0DE);
    sw = 16'hDEAD; btn = 1'b1;
    k = 0;
    while (!dbg_wr_req && k < 30) begin tick(1); k++; end
    check("rstreq_req_seen", dbg_wr_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_req",   dbg_wr_req, 1'b0);
    check("async_hold",  hold, 1'b0);
    check("async_state", dbg_state, 2'd0);
    btn = 1'b0;
    tick(3);
    rst = 1'b0;
    m_cnt = '0; m_err = 1'b0; m_addr = '0; m_data = '0;
    tick(2);
    check("post_rst_count", dbg_wr_count, 8'd0);
    check("post_rst_addr",  dbg_wr_addr, 16'h0);

    // 256 completed writes from zero wrap the counter back to 0.
    for (int i = 0; i < 256; i++)
      do_write(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
               int'($urandom_range(1, 3)));
    check("wrap_count", dbg_wr_count, 8'd0);

    tick(4);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
